// File: rtl/dbg_loader_if.sv
// Host command/response channel for the debug loader.
// Host drives commands and response ready; the loader answers.
interface dbg_loader_if #(
    parameter int XLEN = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [XLEN-1:0] cmd_addr;
    logic [XLEN-1:0] cmd_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dbg_loader.sv
// Debug/load responder: imem writes, dmem/regfile readback, core run control.
// Owns core reset and the second ports of imem, dmem and register file.
module dbg_loader #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    dbg_loader_if.slave                   bus,
    output logic                          core_rst,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [XLEN-1:0]               imem_wdata,
    output logic                          dmem_re,
    output logic [$clog2(DMEM_DEPTH)-1:0] dmem_raddr,
    input  logic [XLEN-1:0]               dmem_rdata,
    output logic [4:0]                    rf_raddr,
    input  logic [XLEN-1:0]               rf_rdata
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [1:0] OP_IMEM = 2'b00;
    localparam logic [1:0] OP_DMEM = 2'b01;
    localparam logic [1:0] OP_REG  = 2'b10;
    localparam logic [1:0] OP_RUN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, CHECK, WRITE, RD_WAIT, RESP
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      cnt;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_err_q;

    logic [XLEN-1:0] widx;
    logic            mis;
    logic            err;

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Memory ports are shared with the core, so only touch them while halted.
    always_comb begin
        widx = {2'b00, addr_q[XLEN-1:2]};
        mis  = |addr_q[1:0];
        err  = 1'b0;
        unique case (op_q)
            OP_IMEM: err = mis || (widx >= XLEN'(IMEM_DEPTH)) || !core_rst;
            OP_DMEM: err = mis || (widx >= XLEN'(DMEM_DEPTH)) || !core_rst;
            OP_REG:  err = !core_rst;
            OP_RUN:  err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            core_rst    <= 1'b1;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            dmem_re     <= 1'b0;
            dmem_raddr  <= '0;
            rf_raddr    <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_re <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q     <= bus.cmd_op;
                        addr_q   <= bus.cmd_addr;
                        wdata_q  <= bus.cmd_wdata;
                        rf_raddr <= bus.cmd_addr[4:0];
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    rsp_err_q  <= err;
                    rsp_data_q <= '0;
                    if (err) begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        unique case (op_q)
                            OP_IMEM: begin
                                imem_we    <= 1'b1;
                                imem_waddr <= addr_q[IW+1:2];
                                imem_wdata <= wdata_q;
                                state      <= WRITE;
                            end
                            OP_DMEM: begin
                                dmem_re    <= 1'b1;
                                dmem_raddr <= addr_q[DW+1:2];
                                cnt        <= '0;
                                state      <= RD_WAIT;
                            end
                            OP_REG: begin
                                rsp_data_q  <= (addr_q[4:0] == 5'd0) ? '0 : rf_rdata;
                                rsp_valid_q <= 1'b1;
                                state       <= RESP;
                            end
                            OP_RUN: begin
                                core_rst    <= ~wdata_q[0];
                                rsp_valid_q <= 1'b1;
                                state       <= RESP;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RD_WAIT: begin
                    // cnt==0 is the dmem_re cycle; data lands RD_LAT later.
                    if (cnt == 3'(RD_LAT)) begin
                        rsp_data_q  <= dmem_rdata;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: directed vector table, corner sequences,
// and random commands checked against a command-level reference model.
module tb_dbg_loader;
    localparam int XLEN   = 32;
    localparam int IMEM_D = 256;
    localparam int DMEM_D = 256;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        core_rst;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        dmem_re;
    logic [7:0]  dmem_raddr;
    logic [31:0] dmem_rdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;

    dbg_loader_if #(.XLEN(XLEN)) b ();

    dbg_loader #(
        .XLEN(XLEN), .IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(b),
        .core_rst(core_rst),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_re(dmem_re), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [31:0] dmem_m [DMEM_D];
    logic [31:0] rf_m   [32];
    logic [31:0] imem_m [IMEM_D];
    bit          imem_wr[IMEM_D];
    logic [31:0] imem_sh[IMEM_D];
    bit          halted;

    // dmem with RD_LAT-cycle read delay; poison outside the valid slot
    logic [31:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= dmem_re ? dmem_m[dmem_raddr] : 32'hBAD0BAD0;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dmem_rdata = pipe[RD_LAT-1];
    assign rf_rdata   = rf_m[rf_raddr];

    logic prev_we;
    always @(posedge clk) begin
        prev_we <= imem_we;
        if (imem_we) imem_sh[imem_waddr] <= imem_wdata;
        if (imem_we && dmem_re) viol <= viol + 1;
        if ((imem_we || dmem_re) && !core_rst) viol <= viol + 1;
        if (imem_we && prev_we) viol <= viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: spec rules applied to one whole command.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w,
                         output logic e, output logic [31:0] d, output int nwe, output int nre);
        e = 1'b0; d = '0; nwe = 0; nre = 0;
        case (op)
            2'b00: begin
                e = (a[1:0] != 0) || ((a >> 2) >= IMEM_D) || !halted;
                if (!e) begin
                    imem_m[a[9:2]]  = w;
                    imem_wr[a[9:2]] = 1'b1;
                    nwe = 1;
                end
            end
            2'b01: begin
                e = (a[1:0] != 0) || ((a >> 2) >= DMEM_D) || !halted;
                if (!e) begin
                    d = dmem_m[a[9:2]];
                    nre = 1;
                end
            end
            2'b10: begin
                e = !halted;
                if (!e && a[4:0] != 0) d = rf_m[a[4:0]];
            end
            default: halted = !w[0];
        endcase
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w,
                          output logic e, output logic [31:0] d,
                          output int nwe, output int nre, output int lat,
                          output logic [31:0] wa, output logic [31:0] wd, output bit to);
        int n;
        int ren;
        e = 0; d = 0; nwe = 0; nre = 0; lat = -1; wa = 0; wd = 0; to = 0; ren = -1;
        @(negedge clk);
        b.cmd_valid = 1'b1; b.cmd_op = op; b.cmd_addr = a; b.cmd_wdata = w;
        n = 0;
        while (!b.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b.cmd_ready) begin
            to = 1;
            b.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 b.cmd_valid = 1'b0;
            n = 0;
            while (!to) begin
                @(negedge clk);
                n++;
                if (imem_we) begin nwe++; wa = 32'(imem_waddr); wd = imem_wdata; end
                if (dmem_re) begin nre++; ren = n; end
                if (b.rsp_valid) break;
                if (n > 40) to = 1;
            end
            if (!to) begin
                e = b.rsp_err;
                d = b.rsp_data;
                if (ren >= 0) lat = n - ren;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
        logic        crst;
        int          we;
        int          re;
    } vec_t;

    vec_t tv[16];

    initial begin
        logic        e, me;
        logic [31:0] d, md, wa, wd;
        int          nwe, nre, lat, mwe, mre, k;
        bit          to, seen;
        logic [1:0]  op;
        logic [31:0] a, w;

        for (int i = 0; i < DMEM_D; i++) dmem_m[i] = $urandom;
        for (int i = 0; i < 32; i++) rf_m[i] = $urandom;
        for (int i = 0; i < IMEM_D; i++) begin imem_m[i] = '0; imem_wr[i] = 1'b0; end
        dmem_m[1]   = 32'hDEADBEEF;
        rf_m[3]     = 32'h00000007;
        rf_m[0]     = 32'hFFFFFFFF;
        halted      = 1'b1;

        tv[0]  = '{2'b00, 32'h0,        32'h002201B3, 1'b0, 32'h0,        1'b1, 1, 0};
        tv[1]  = '{2'b00, 32'h2,        32'h11111111, 1'b1, 32'h0,        1'b1, 0, 0};
        tv[2]  = '{2'b00, 32'h400,      32'h22222222, 1'b1, 32'h0,        1'b1, 0, 0};
        tv[3]  = '{2'b11, 32'h0,        32'h1,        1'b0, 32'h0,        1'b0, 0, 0};
        tv[4]  = '{2'b01, 32'h4,        32'h0,        1'b1, 32'h0,        1'b0, 0, 0};
        tv[5]  = '{2'b10, 32'h3,        32'h0,        1'b1, 32'h0,        1'b0, 0, 0};
        tv[6]  = '{2'b11, 32'h0,        32'h1,        1'b0, 32'h0,        1'b0, 0, 0};
        tv[7]  = '{2'b11, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
        tv[8]  = '{2'b11, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
        tv[9]  = '{2'b01, 32'h4,        32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 0, 1};
        tv[10] = '{2'b10, 32'h3,        32'h0,        1'b0, 32'h7,        1'b1, 0, 0};
        tv[11] = '{2'b10, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
        tv[12] = '{2'b10, 32'hFFFFFFE3, 32'h0,        1'b0, 32'h7,        1'b1, 0, 0};
        tv[13] = '{2'b01, 32'h400,      32'h0,        1'b1, 32'h0,        1'b1, 0, 0};
        tv[14] = '{2'b01, 32'h5,        32'h0,        1'b1, 32'h0,        1'b1, 0, 0};
        tv[15] = '{2'b00, 32'h3FC,      32'h12345678, 1'b0, 32'h0,        1'b1, 1, 0};

        rst = 1'b1;
        b.cmd_valid = 1'b0; b.cmd_op = '0; b.cmd_addr = '0; b.cmd_wdata = '0;
        b.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(b.cmd_ready), 0);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 0);
        chk("rst_rsp_data", b.rsp_data, 0);
        chk("rst_rsp_err", 32'(b.rsp_err), 0);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_strobes", {30'd0, imem_we, dmem_re}, 0);
        chk("rst_addrs", {11'd0, imem_waddr, dmem_raddr, rf_raddr}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(b.cmd_ready), 1);

        for (int i = 0; i < 16; i++) begin
            do_cmd(tv[i].op, tv[i].addr, tv[i].wdata, e, d, nwe, nre, lat, wa, wd, to);
            model(tv[i].op, tv[i].addr, tv[i].wdata, me, md, mwe, mre);
            chk($sformatf("v%0d_timeout", i), 32'(to), 0);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(tv[i].err));
            chk($sformatf("v%0d_data", i), d, tv[i].data);
            chk($sformatf("v%0d_core_rst", i), 32'(core_rst), 32'(tv[i].crst));
            chk($sformatf("v%0d_we_pulses", i), 32'(nwe), 32'(tv[i].we));
            chk($sformatf("v%0d_re_pulses", i), 32'(nre), 32'(tv[i].re));
            if (tv[i].we == 1) begin
                chk($sformatf("v%0d_waddr", i), wa, tv[i].addr >> 2);
                chk($sformatf("v%0d_wdata", i), wd, tv[i].wdata);
            end
            if (tv[i].re == 1) chk($sformatf("v%0d_rd_lat", i), 32'(lat), 32'(RD_LAT + 1));
        end

        // response back-pressure
        b.rsp_ready = 1'b0;
        @(negedge clk);
        b.cmd_valid = 1'b1; b.cmd_op = 2'b10; b.cmd_addr = 32'h3;
        @(posedge clk);
        #1 b.cmd_valid = 1'b0;
        k = 0;
        while (!b.rsp_valid && k < 20) begin @(negedge clk); k++; end
        chk("bp_rsp_seen", 32'(b.rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {b.rsp_valid, b.cmd_ready, b.rsp_err, 29'd0} | (b.rsp_data ^ 32'h7),
                {1'b1, 1'b0, 1'b0, 29'd0});
        end
        b.rsp_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_release", 32'(b.rsp_valid), 0);

        // reset during RD_WAIT
        @(negedge clk);
        b.cmd_valid = 1'b1; b.cmd_op = 2'b01; b.cmd_addr = 32'h4;
        @(posedge clk);
        #1 b.cmd_valid = 1'b0;
        k = 0;
        while (!dmem_re && k < 10) begin @(negedge clk); k++; end
        chk("rstmid_re_seen", 32'(dmem_re), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 32'(b.rsp_valid), 0);
        chk("rstmid_strobes", {30'd0, imem_we, dmem_re}, 0);
        chk("rstmid_core_rst", 32'(core_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b.rsp_valid || dmem_re || imem_we) seen = 1;
        end
        chk("rstmid_no_stale", 32'(seen), 0);
        chk("rstmid_idle", 32'(b.cmd_ready), 1);
        halted = 1'b1;

        // async reset halts a running core without a clock edge
        do_cmd(2'b11, 0, 1, e, d, nwe, nre, lat, wa, wd, to);
        model(2'b11, 0, 1, me, md, mwe, mre);
        chk("run_core_rst", 32'(core_rst), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_core_rst", 32'(core_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        halted = 1'b1;

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 99);
            op = (k < 12) ? 2'b11 : 2'($urandom_range(0, 2));
            a = {22'd0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a = a + 32'h400;
            if ($urandom_range(0, 29) == 0) a = $urandom;
            w = $urandom;
            if (op == 2'b11 && $urandom_range(0, 2) != 0) w[0] = 1'b0;
            model(op, a, w, me, md, mwe, mre);
            do_cmd(op, a, w, e, d, nwe, nre, lat, wa, wd, to);
            chk($sformatf("r%0d_timeout", i), 32'(to), 0);
            chk($sformatf("r%0d_rsp", i), d ^ {31'd0, e}, md ^ {31'd0, me});
            chk($sformatf("r%0d_pulses", i), 32'(nwe * 2 + nre), 32'(mwe * 2 + mre));
            chk($sformatf("r%0d_core_rst", i), 32'(core_rst), 32'(halted));
        end

        for (int i = 0; i < IMEM_D; i++)
            if (imem_wr[i]) chk($sformatf("imem_%0d", i), imem_sh[i], imem_m[i]);
        chk("invariants", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
